// File: rtl/uart_rx_capture.sv
// rtl/uart_rx_capture.sv - UART receiver (8N1) with first-word-fall-through output FIFO
// Optional even-parity bit and parity_err_o port: define UART_RX_PARITY_EN.
module uart_rx_capture #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 781250,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  input  logic                          rx_en_i,
  input  logic                          clear_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err_o
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_MID = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  logic [1:0]    sync;
  logic          rxs;
  state_t        state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          push, fe_n;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, par_bad_n, pe_n;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          full, pop, wr_ok;

  assign rxs = sync[1];

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx_i};
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_idx     <= idx_n;
      shift       <= shift_n;
      frame_err_o <= fe_n;
`ifdef UART_RX_PARITY_EN
      par_bad      <= par_bad_n;
      parity_err_o <= pe_n;
`endif
    end
  end

  // Next-state logic: START re-checks at half a bit, later states sample at bit centres
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt + 1'b1;
    idx_n   = bit_idx;
    shift_n = shift;
    push    = 1'b0;
    fe_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    pe_n      = 1'b0;
`endif
    if (!rx_en_i) begin
      state_n = IDLE;
      tick_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          tick_n = '0;
          if (!rxs) state_n = START;
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_n  = '0;
            idx_n   = '0;
            state_n = rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick_cnt == TICK_END) begin
            tick_n  = '0;
            shift_n = {rxs, shift[7:1]};
            idx_n   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt == TICK_END) begin
            tick_n    = '0;
            par_bad_n = rxs ^ (^shift);
            state_n   = STOP;
          end
        end
`endif
        STOP: begin
          if (tick_cnt == TICK_END) begin
            tick_n = '0;
`ifdef UART_RX_PARITY_EN
            pe_n = par_bad;
`endif
            if (rxs) begin
`ifdef UART_RX_PARITY_EN
              push = !par_bad;
`else
              push = 1'b1;
`endif
              state_n = IDLE;
            end else begin
              fe_n    = 1'b1;
              state_n = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          tick_n = '0;
          if (rxs) state_n = IDLE;
        end
        default: begin
          tick_n  = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  assign valid_o = (count_o != '0);
  assign full    = (count_o == FULL_CNT);
  assign pop     = valid_o & ready_i;
  assign wr_ok   = push & (!full | pop);
  assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;

  // FIFO storage; no reset needed since data_o is gated by valid_o
  always_ff @(posedge clk) begin
    if (wr_ok && !clear_i) mem[wr_ptr] <= shift;
  end

  // FIFO pointers, occupancy and sticky overrun; clear overrides push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_o   <= '0;
      overrun_o <= 1'b0;
    end else if (clear_i) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_o   <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !pop)      count_o <= count_o + 1'b1;
      else if (!wr_ok && pop) count_o <= count_o - 1'b1;
      if (push && full && !pop) overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_capture.sv
// tb/tb_uart_rx_capture.sv - directed self-checking bench for uart_rx_capture
module tb_uart_rx_capture;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int BIT_CLKS = 32;
  localparam int NB       = PAR ? 11 : 10;
  localparam int STOP_POP = BIT_CLKS * (NB - 1) + 18;
  localparam int VALID_AT = STOP_POP + 1;

  logic       clk = 1'b0;
  logic       rst, rx, rx_en, clear, ready;
  logic [7:0] data;
  logic       valid, frame_err, overrun;
  logic [4:0] count;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         pe_cnt = 0;
`endif

  int         checks = 0;
  int         errors = 0;
  int         fe_cnt = 0;
  int         first_valid;
  logic       bad_par = 1'b0;
  logic [7:0] rxq[$];

  uart_rx_capture dut (
    .clk(clk), .rst(rst), .rx_i(rx), .rx_en_i(rx_en), .clear_i(clear),
    .data_o(data), .valid_o(valid), .ready_i(ready),
    .frame_err_o(frame_err), .overrun_o(overrun), .count_o(count)
`ifdef UART_RX_PARITY_EN
    , .parity_err_o(parity_err)
`endif
  );

  always #20 clk = ~clk;

  always begin
    @(negedge clk);
    #1;
    if (valid && ready) rxq.push_back(data);
    if (frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
  end

  task automatic send_char(input logic [7:0] c, input logic stop_bit, input int pop_at);
    logic [10:0] frame;
    int k;
    frame = {stop_bit, (^c) ^ bad_par, c, 1'b0};
    k = 0;
    first_valid = -1;
    for (int i = 0; i < 11; i++) begin
      if (i == 9 && !PAR) continue;
      rx = frame[i];
      repeat (BIT_CLKS) begin
        @(negedge clk);
        k++;
        if (valid && first_valid < 0) first_valid = k;
        if (k == pop_at) ready = 1'b1;
        else if (k == pop_at + 1) ready = 1'b0;
      end
    end
  endtask

  task automatic drain;
    ready = 1'b1;
    repeat (20) @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; rx_en = 1'b1; clear = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00)   begin errors++; $display("FAIL reset_data got %h want 00", data); end
    checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (count !== 5'd0)   begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    rxq.delete(); ready = 1'b1; fe_cnt = 0;
    send_char(8'h65, 1'b1, -1);
    repeat (4) @(negedge clk);
    checks++; if (first_valid != VALID_AT) begin errors++; $display("FAIL basic_latency got %0d want %0d", first_valid, VALID_AT); end
    checks++; if (rxq.size() != 1) begin errors++; $display("FAIL basic_popped got %0d want 1", rxq.size()); end
    else begin
      checks++; if (rxq[0] !== 8'h65) begin errors++; $display("FAIL basic_data got %h want 65", rxq[0]); end
    end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL basic_count got %0d want 0", count); end
    ready = 1'b0;
  endtask

  task automatic test_glitch;
    rxq.delete(); fe_cnt = 0;
    @(negedge clk);
    #5 rx = 1'b0;
    #20 rx = 1'b1;
    repeat (BIT_CLKS * 2) @(negedge clk);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL glitch_count got %0d want 0", count); end
    checks++; if (fe_cnt != 0) begin errors++; $display("FAIL glitch_frame_err got %0d want 0", fe_cnt); end
    send_char(8'h5A, 1'b1, -1);
    repeat (4) @(negedge clk);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL glitch_next_count got %0d want 1", count); end
    checks++; if (data !== 8'h5A) begin errors++; $display("FAIL glitch_next_data got %h want 5a", data); end
    drain();
  endtask

  task automatic test_frame_err;
    rxq.delete(); fe_cnt = 0;
    send_char(8'h41, 1'b0, -1);
    rx = 1'b0;
    repeat (BIT_CLKS * 10) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS * 2) @(negedge clk);
    checks++; if (fe_cnt != 1) begin errors++; $display("FAIL fe_pulses got %0d want 1", fe_cnt); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL fe_count got %0d want 0", count); end
    send_char(8'h42, 1'b1, -1);
    repeat (4) @(negedge clk);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL fe_after_count got %0d want 1", count); end
    drain();
    checks++; if (rxq.size() != 1 || rxq[0] !== 8'h42) begin errors++; $display("FAIL fe_after_data got size %0d want 1 char 42", rxq.size()); end
    checks++; if (fe_cnt != 1) begin errors++; $display("FAIL fe_total got %0d want 1", fe_cnt); end
  endtask

  task automatic test_overrun;
    rxq.delete(); ready = 1'b0;
    for (int i = 0; i < 17; i++) send_char(8'(i), 1'b1, -1);
    repeat (4) @(negedge clk);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovr_count got %0d want 16", count); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
    drain();
    checks++; if (rxq.size() != 16) begin errors++; $display("FAIL ovr_drain_size got %0d want 16", rxq.size()); end
    for (int i = 0; i < 16 && i < rxq.size(); i++) begin
      checks++; if (rxq[i] !== 8'(i)) begin errors++; $display("FAIL ovr_order[%0d] got %h want %h", i, rxq[i], 8'(i)); end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_full_pop;
    rxq.delete(); ready = 1'b0;
    for (int i = 0; i < 16; i++) send_char(8'(i), 1'b1, -1);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", count); end
    send_char(8'h55, 1'b1, STOP_POP);
    repeat (4) @(negedge clk);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_pop_count got %0d want 16", count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_pop_overrun got %b want 0", overrun); end
    drain();
    checks++; if (rxq.size() != 17) begin errors++; $display("FAIL full_pop_size got %0d want 17", rxq.size()); end
    else begin
      checks++; if (rxq[0] !== 8'h00)  begin errors++; $display("FAIL full_pop_first got %h want 00", rxq[0]); end
      checks++; if (rxq[15] !== 8'h0F) begin errors++; $display("FAIL full_pop_prev got %h want 0f", rxq[15]); end
      checks++; if (rxq[16] !== 8'h55) begin errors++; $display("FAIL full_pop_last got %h want 55", rxq[16]); end
    end
  endtask

  task automatic test_rst_midframe;
    logic [7:0] c;
    rxq.delete(); ready = 1'b0; fe_cnt = 0;
    send_char(8'h11, 1'b1, -1);
    c = 8'hA5;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = c[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = c[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (count !== 5'd0 || valid !== 1'b0) begin errors++; $display("FAIL rst_async got count %0d valid %b want 0 0", count, valid); end
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    repeat (BIT_CLKS * 12) @(negedge clk);
    ready = 1'b1;
    send_char(8'h3C, 1'b1, -1);
    repeat (4) @(negedge clk);
    checks++; if (rxq.size() != 1 || rxq[0] !== 8'h3C) begin errors++; $display("FAIL rst_only_3c got size %0d want 1 char 3c", rxq.size()); end
    checks++; if (fe_cnt != 0) begin errors++; $display("FAIL rst_frame_err got %0d want 0", fe_cnt); end
    ready = 1'b0;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    rxq.delete(); ready = 1'b1; pe_cnt = 0; fe_cnt = 0;
    bad_par = 1'b1;
    send_char(8'h3C, 1'b1, -1);
    bad_par = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (pe_cnt != 1) begin errors++; $display("FAIL parity_pulses got %0d want 1", pe_cnt); end
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL parity_push got %0d want 0", rxq.size()); end
    checks++; if (fe_cnt != 0) begin errors++; $display("FAIL parity_frame_err got %0d want 0", fe_cnt); end
    ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_rst_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
